// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier with signed/unsigned mode select.
// Retires two multiplier bits per RUN cycle behind a start/ready handshake.
module booth_radix4_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sign_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 ready,
  output logic                 busy
);

  localparam int unsigned W2 = WIDTH + 2;
  localparam int unsigned AW = W2 + 2;
  localparam int unsigned N  = W2 / 2;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [AW-1:0]       acc, acc_next;
  logic [W2-1:0]       q, q_next;
  logic                qm1, qm1_next;
  logic [AW-1:0]       m, m_next;
  logic [CW-1:0]       count, count_next;
  logic [2*WIDTH-1:0]  p_next;
  logic                ready_next;
  logic                busy_next;
  logic [AW-1:0]       addend;
  logic [AW-1:0]       sum;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      m     <= '0;
      count <= '0;
      P     <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      q     <= q_next;
      qm1   <= qm1_next;
      m     <= m_next;
      count <= count_next;
      P     <= p_next;
      ready <= ready_next;
      busy  <= busy_next;
    end
  end

  // Booth digit select from {Q[1:0], Qm1}; arithmetic is modulo 2^AW.
  always_comb begin
    addend = '0;
    unique case ({q[1:0], qm1})
      3'b001, 3'b010: addend = m;
      3'b011:         addend = {m[AW-2:0], 1'b0};
      3'b100:         addend = -{m[AW-2:0], 1'b0};
      3'b101, 3'b110: addend = -m;
      default:        addend = '0;
    endcase
    sum = acc + addend;
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    q_next     = q;
    qm1_next   = qm1;
    m_next     = m;
    count_next = count;
    p_next     = P;
    ready_next = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          acc_next   = '0;
          qm1_next   = 1'b0;
          count_next = CW'(N);
          if (sign_mode) begin
            q_next = {{2{B[WIDTH-1]}}, B};
            m_next = {{(AW-WIDTH){A[WIDTH-1]}}, A};
          end else begin
            q_next = W2'(B);
            m_next = AW'(A);
          end
          state_next = RUN;
        end
      end
      RUN: begin
        // Shift the whole {ACC,Q,Qm1} right by two, replicating the new ACC sign.
        acc_next   = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_next     = {sum[1:0], q[W2-1:2]};
        qm1_next   = q[1];
        count_next = count - CW'(1);
        if (count == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        p_next     = (2*WIDTH)'({acc, q});
        ready_next = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
